// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, FSM encoding,
// ALU command codes and the unsupported-command test.
package alu_arb_pkg;

  localparam int OPW  = 8;
  localparam int RESW = 16;
  localparam int CMDW = 5;

  localparam logic [CMDW-1:0] CMD_MAX = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [CMDW-1:0] CMD_ADD  = 5'd0;
  localparam logic [CMDW-1:0] CMD_SUB  = 5'd1;
  localparam logic [CMDW-1:0] CMD_MUL  = 5'd2;
  localparam logic [CMDW-1:0] CMD_SMUL = 5'd3;
  localparam logic [CMDW-1:0] CMD_AND  = 5'd4;
  localparam logic [CMDW-1:0] CMD_OR   = 5'd5;
  localparam logic [CMDW-1:0] CMD_XOR  = 5'd6;
  localparam logic [CMDW-1:0] CMD_NOR  = 5'd7;
  localparam logic [CMDW-1:0] CMD_NAND = 5'd8;
  localparam logic [CMDW-1:0] CMD_XNOR = 5'd9;
  localparam logic [CMDW-1:0] CMD_NOT  = 5'd10;
  localparam logic [CMDW-1:0] CMD_SHL  = 5'd11;
  localparam logic [CMDW-1:0] CMD_SHR  = 5'd12;
  localparam logic [CMDW-1:0] CMD_ASR  = 5'd13;
  localparam logic [CMDW-1:0] CMD_ROL  = 5'd14;
  localparam logic [CMDW-1:0] CMD_ROR  = 5'd15;
  localparam logic [CMDW-1:0] CMD_INC  = 5'd16;
  localparam logic [CMDW-1:0] CMD_DEC  = 5'd17;
  localparam logic [CMDW-1:0] CMD_MIN  = 5'd18;
  localparam logic [CMDW-1:0] CMD_MAX8 = 5'd19;
  localparam logic [CMDW-1:0] CMD_EQ   = 5'd20;
  localparam logic [CMDW-1:0] CMD_LT   = 5'd21;
  localparam logic [CMDW-1:0] CMD_SLT  = 5'd22;
  localparam logic [CMDW-1:0] CMD_ABSD = 5'd23;

  function automatic logic cmd_unsupported(input logic [CMDW-1:0] c);
    return c > CMD_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU_8bit: combinational 8-bit ALU with a 16-bit result. Output is forced to
// zero whenever enable is low so an idle datapath presents a quiet bus.
module ALU_8bit
  import alu_arb_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [CMDW-1:0] command,
  input  logic            enable,
  output logic [RESW-1:0] y
);

  logic        [RESW-1:0] ua, ub, res;
  logic signed [RESW-1:0] sa, sb;
  logic        [2:0]      sh;
  logic        [OPW-1:0]  rol8, ror8;

  assign ua   = {{(RESW-OPW){1'b0}}, a};
  assign ub   = {{(RESW-OPW){1'b0}}, b};
  assign sa   = {{(RESW-OPW){a[OPW-1]}}, a};
  assign sb   = {{(RESW-OPW){b[OPW-1]}}, b};
  assign sh   = b[2:0];
  assign rol8 = (a << sh) | (a >> (4'd8 - {1'b0, sh}));
  assign ror8 = (a >> sh) | (a << (4'd8 - {1'b0, sh}));

  // Command decode; codes above CMD_MAX yield zero
  always_comb begin
    res = '0;
    case (command)
      CMD_ADD:  res = ua + ub;
      CMD_SUB:  res = ua - ub;
      CMD_MUL:  res = ua * ub;
      CMD_SMUL: res = sa * sb;
      CMD_AND:  res = ua & ub;
      CMD_OR:   res = ua | ub;
      CMD_XOR:  res = ua ^ ub;
      CMD_NOR:  res = {{(RESW-OPW){1'b0}}, ~(a | b)};
      CMD_NAND: res = {{(RESW-OPW){1'b0}}, ~(a & b)};
      CMD_XNOR: res = {{(RESW-OPW){1'b0}}, ~(a ^ b)};
      CMD_NOT:  res = {{(RESW-OPW){1'b0}}, ~a};
      CMD_SHL:  res = ua << sh;
      CMD_SHR:  res = ua >> sh;
      CMD_ASR:  res = sa >>> sh;
      CMD_ROL:  res = {{(RESW-OPW){1'b0}}, rol8};
      CMD_ROR:  res = {{(RESW-OPW){1'b0}}, ror8};
      CMD_INC:  res = ua + 16'd1;
      CMD_DEC:  res = ua - 16'd1;
      CMD_MIN:  res = (ua < ub) ? ua : ub;
      CMD_MAX8: res = (ua > ub) ? ua : ub;
      CMD_EQ:   res = {15'd0, a == b};
      CMD_LT:   res = {15'd0, ua < ub};
      CMD_SLT:  res = {15'd0, sa < sb};
      CMD_ABSD: res = (ua >= ub) ? (ua - ub) : (ub - ua);
      default:  res = '0;
    endcase
  end

  assign y = enable ? res : '0;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU_8bit between two
// requesters. One operation in flight: IDLE accepts, EXEC holds the ALU
// enabled for SETTLE_CYCLES, RESP presents the registered result.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic [CMDW-1:0] req0_cmd,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  input  logic [CMDW-1:0] req1_cmd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [RESW-1:0] resp_y,
  output logic            resp_id,
  output logic            resp_err,
  output logic            busy
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e          state, state_nxt;
  logic [3:0]      settle_cnt;
  logic            settle_done;
  logic            last_grant;
  logic            grant0, grant1;
  logic            accept;
  logic            sel;
  logic            id_q, err_q;
  logic            alu_en;
  logic [RESW-1:0] alu_y;
  logic [OPW-1:0]  op_a_p0, op_b_p0;
  logic [CMDW-1:0] cmd_p0;

  assign settle_done = (settle_cnt == SETTLE_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept -> EXEC -> (settle done) RESP -> (handshake) IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)      state_nxt = ST_EXEC;
      ST_EXEC: if (settle_done) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready)  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: grant on tie goes to the requester not granted last; ready is
  // gated by rst_n so it reads low for the whole reset window
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = rst_n && (state == ST_IDLE) && grant0;
    req1_ready = rst_n && (state == ST_IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    sel        = req1_ready;
    busy       = (state != ST_IDLE);
    resp_valid = (state == ST_RESP);
    alu_en     = (state == ST_EXEC) && !err_q;
  end

  // ---- stage p0: operands captured on accept, held stable through EXEC ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_p0 <= sel ? req1_a   : req0_a;
      op_b_p0 <= sel ? req1_b   : req0_b;
      cmd_p0  <= sel ? req1_cmd : req0_cmd;
    end
  end

  ALU_8bit u_alu (
    .a       (op_a_p0),
    .b       (op_b_p0),
    .command (cmd_p0),
    .enable  (alu_en),
    .y       (alu_y)
  );

  // ---- stage p1: arbitration bookkeeping, settle count and result capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      resp_y     <= '0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      last_grant <= sel;
      id_q       <= sel;
      err_q      <= cmd_unsupported(sel ? req1_cmd : req0_cmd);
      settle_cnt <= '0;
    end else if (state == ST_EXEC) begin
      if (settle_done) begin
        settle_cnt <= '0;
        resp_y     <= err_q ? '0 : alu_y;
        resp_id    <= id_q;
        resp_err   <= err_q;
      end else begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of arbitration, timing and ALU results.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance with SETTLE_CYCLES = 1
  logic        v0 = 0, v1 = 0, r0, r1, rv, rr = 1, rid, rerr, bsy;
  logic [7:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [4:0]  c0 = 0, c1 = 0;
  logic [15:0] ry;

  // Instance with SETTLE_CYCLES = 3
  logic        t_v0 = 0, t_v1 = 0, t_r0, t_r1, t_rv, t_rr = 1, t_rid, t_rerr, t_bsy;
  logic [7:0]  t_a0 = 0, t_b0 = 0, t_a1 = 0, t_b1 = 0;
  logic [4:0]  t_c0 = 0, t_c1 = 0;
  logic [15:0] t_ry;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cmd(c0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cmd(c1),
    .resp_valid(rv), .resp_ready(rr), .resp_y(ry), .resp_id(rid), .resp_err(rerr),
    .busy(bsy)
  );

  alu_arbiter #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t_v0), .req0_ready(t_r0), .req0_a(t_a0), .req0_b(t_b0), .req0_cmd(t_c0),
    .req1_valid(t_v1), .req1_ready(t_r1), .req1_a(t_a1), .req1_b(t_b1), .req1_cmd(t_c1),
    .resp_valid(t_rv), .resp_ready(t_rr), .resp_y(t_ry), .resp_id(t_rid), .resp_err(t_rerr),
    .busy(t_bsy)
  );

  // Reference ALU from the command table using plain integer arithmetic
  function automatic logic [15:0] ref_alu(input int a, input int b, input int cmd);
    int sa, sb, s, r;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    s  = b % 8;
    case (cmd)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
      3:  r = sa * sb;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = (~(a | b)) & 255;
      8:  r = (~(a & b)) & 255;
      9:  r = (~(a ^ b)) & 255;
      10: r = (~a) & 255;
      11: r = a * (1 << s);
      12: r = a / (1 << s);
      13: r = sa >>> s;
      14: r = ((a << s) | (a >> (8 - s))) & 255;
      15: r = ((a >> s) | (a << (8 - s))) & 255;
      16: r = a + 1;
      17: r = a - 1;
      18: r = (a < b) ? a : b;
      19: r = (a > b) ? a : b;
      20: r = (a == b) ? 1 : 0;
      21: r = (a < b) ? 1 : 0;
      22: r = (sa < sb) ? 1 : 0;
      23: r = (a >= b) ? a - b : b - a;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Waits on negedges of the SETTLE=1 instance for resp_valid; lat counts cycles
  task automatic wait_resp_a(output int lat, output bit got);
    got = 0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (rv) begin
        lat = k;
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    v0 = 1; v1 = 1;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (r0 !== 1'b0)  begin n_fail++; $display("FAIL reset_req0_ready: got %0b expected 0", r0); end
    n_checks++; if (r1 !== 1'b0)  begin n_fail++; $display("FAIL reset_req1_ready: got %0b expected 0", r1); end
    n_checks++; if (rv !== 1'b0)  begin n_fail++; $display("FAIL reset_resp_valid: got %0b expected 0", rv); end
    n_checks++; if (ry !== 16'h0) begin n_fail++; $display("FAIL reset_resp_y: got %0h expected 0", ry); end
    n_checks++; if (rid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_id: got %0b expected 0", rid); end
    n_checks++; if (rerr !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %0b expected 0", rerr); end
    n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bsy); end
    n_checks++; if (dut.alu_en !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en: got %0b expected 0", dut.alu_en); end
    @(posedge clk);
    #1;
    n_checks++; if (r0 !== 1'b0 || bsy !== 1'b0) begin n_fail++; $display("FAIL reset_held: ready0=%0b busy=%0b expected 0 0", r0, bsy); end
    rst_n = 1'b1;
    v0 = 0; v1 = 0;
    tick();
  endtask

  task automatic test_single();
    int lat; bit got;
    v0 = 1; a0 = 8'd15; b0 = 8'd10; c0 = 5'd0; rr = 1;
    @(negedge clk);
    n_checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin n_fail++; $display("FAIL single_grant: ready0=%0b ready1=%0b expected 1 0", r0, r1); end
    tick();
    v0 = 0;
    wait_resp_a(lat, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL single_timeout: no resp_valid expected within 30 cycles"); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
    n_checks++; if (ry !== ref_alu(15, 10, 0)) begin n_fail++; $display("FAIL single_y: got %0h expected %0h", ry, ref_alu(15, 10, 0)); end
    n_checks++; if (rid !== 1'b0 || rerr !== 1'b0) begin n_fail++; $display("FAIL single_id_err: got %0b %0b expected 0 0", rid, rerr); end
    tick();
    @(negedge clk);
    n_checks++; if (bsy !== 1'b0 || rv !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: busy=%0b valid=%0b expected 0 0", bsy, rv); end
    tick();
  endtask

  task automatic test_tie();
    int lat; bit got;
    bit exp_id [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] exp_y;
    do_reset();
    v0 = 1; a0 = 8'd3; b0 = 8'd4; c0 = 5'd0;
    v1 = 1; a1 = 8'd9; b1 = 8'd2; c1 = 5'd2;
    rr = 1;
    for (int i = 0; i < 3; i++) begin
      got = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (r0 || r1) begin got = 1; break; end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL tie_grant_timeout: op %0d no grant within 20 cycles", i); end
      n_checks++; if (r1 !== exp_id[i] || r0 !== !exp_id[i]) begin n_fail++; $display("FAIL tie_grant: op %0d ready0=%0b ready1=%0b expected requester %0d", i, r0, r1, exp_id[i]); end
      tick();
      wait_resp_a(lat, got);
      exp_y = exp_id[i] ? ref_alu(9, 2, 2) : ref_alu(3, 4, 0);
      n_checks++; if (!got || rid !== exp_id[i]) begin n_fail++; $display("FAIL tie_resp_id: op %0d got %0b expected %0b", i, rid, exp_id[i]); end
      n_checks++; if (ry !== exp_y) begin n_fail++; $display("FAIL tie_resp_y: op %0d got %0h expected %0h", i, ry, exp_y); end
      n_checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin n_fail++; $display("FAIL tie_no_accept_in_handshake: ready0=%0b ready1=%0b expected 0 0", r0, r1); end
      tick();
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_backpressure();
    int lat; bit got;
    logic [15:0] exp_y;
    rr = 0;
    v1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); c1 = 5'($urandom_range(0, 23));
    exp_y = ref_alu(int'(a1), int'(b1), int'(c1));
    @(negedge clk);
    n_checks++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL bp_grant: ready1=%0b expected 1", r1); end
    tick();
    v1 = 0; v0 = 1;
    wait_resp_a(lat, got);
    n_checks++; if (!got || ry !== exp_y || rid !== 1'b1) begin n_fail++; $display("FAIL bp_first: y=%0h id=%0b expected %0h 1", ry, rid, exp_y); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (rv !== 1'b1 || ry !== exp_y || rid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: cycle %0d valid=%0b y=%0h id=%0b expected 1 %0h 1", k, rv, ry, rid, exp_y); end
      n_checks++; if (r0 !== 1'b0 || r1 !== 1'b0 || bsy !== 1'b1) begin n_fail++; $display("FAIL bp_ctrl: cycle %0d ready0=%0b ready1=%0b busy=%0b expected 0 0 1", k, r0, r1, bsy); end
    end
    tick();
    rr = 1;
    @(negedge clk);
    n_checks++; if (rv !== 1'b1 || r0 !== 1'b0) begin n_fail++; $display("FAIL bp_release: valid=%0b ready0=%0b expected 1 0", rv, r0); end
    tick();
    @(negedge clk);
    n_checks++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: ready0=%0b expected 1", r0); end
    tick();
    v0 = 0;
    wait_resp_a(lat, got);
    tick();
  endtask

  task automatic test_bad_cmd();
    logic [4:0] bad [2] = '{5'b11000, 5'b11111};
    int lat; bit got; bit en_seen;
    for (int i = 0; i < 2; i++) begin
      en_seen = 0;
      v1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); c1 = bad[i]; rr = 1;
      @(negedge clk);
      n_checks++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL bad_grant: ready1=%0b expected 1", r1); end
      tick();
      v1 = 0;
      got = 0; lat = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (dut.alu_en) en_seen = 1;
        if (rv) begin lat = k; got = 1; break; end
      end
      n_checks++; if (!got || lat != 2) begin n_fail++; $display("FAIL bad_latency: cmd %0d got %0d expected 2", bad[i], lat); end
      n_checks++; if (rerr !== 1'b1 || ry !== 16'h0 || rid !== 1'b1) begin n_fail++; $display("FAIL bad_resp: err=%0b y=%0h id=%0b expected 1 0 1", rerr, ry, rid); end
      n_checks++; if (en_seen) begin n_fail++; $display("FAIL bad_alu_en: enable seen high, expected never"); end
      tick();
    end
  endtask

  task automatic test_reset_mid_exec();
    int lat; bit got; bit seen;
    v0 = 1; a0 = 8'd77; b0 = 8'd5; c0 = 5'd1; rr = 1;
    @(negedge clk);
    n_checks++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL rst_exec_grant: ready0=%0b expected 1", r0); end
    tick();
    v0 = 0;
    @(negedge clk);
    n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL rst_exec_busy: got %0b expected 1", bsy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL rst_exec_idle: busy=%0b expected 0", bsy); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv) seen = 1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_exec_dropped: resp_valid seen, expected none"); end
    tick();
    v0 = 1; v1 = 1; a0 = 8'd200; b0 = 8'd100; c0 = 5'd23; a1 = 8'd1; b1 = 8'd1; c1 = 5'd0;
    @(negedge clk);
    n_checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin n_fail++; $display("FAIL rst_exec_next: ready0=%0b ready1=%0b expected 1 0", r0, r1); end
    tick();
    v0 = 0; v1 = 0;
    wait_resp_a(lat, got);
    n_checks++; if (!got || lat != 2 || ry !== ref_alu(200, 100, 23) || rid !== 1'b0) begin n_fail++; $display("FAIL rst_exec_next_resp: lat=%0d y=%0h id=%0b expected 2 %0h 0", lat, ry, rid, ref_alu(200, 100, 23)); end
    tick();
  endtask

  task automatic test_settle_sweep();
    int lat, en_cnt; bit got; bit id;
    logic [15:0] exp_y;
    for (int i = 0; i < 4; i++) begin
      t_rr = 1;
      if (i == 0) begin
        id = 0; t_a0 = 8'd40; t_b0 = 8'd8; t_c0 = 5'd3;
        exp_y = ref_alu(40, 8, 3);
      end else begin
        id = 1'($urandom_range(0, 1));
        t_a0 = 8'($urandom); t_b0 = 8'($urandom); t_c0 = 5'($urandom_range(0, 23));
        t_a1 = 8'($urandom); t_b1 = 8'($urandom); t_c1 = 5'($urandom_range(0, 23));
        exp_y = id ? ref_alu(int'(t_a1), int'(t_b1), int'(t_c1)) : ref_alu(int'(t_a0), int'(t_b0), int'(t_c0));
      end
      t_v0 = !id; t_v1 = id;
      @(negedge clk);
      n_checks++; if (t_r0 !== !id || t_r1 !== id) begin n_fail++; $display("FAIL sweep_grant: op %0d ready0=%0b ready1=%0b expected requester %0d", i, t_r0, t_r1, id); end
      tick();
      t_v0 = 0; t_v1 = 0;
      en_cnt = 0; got = 0; lat = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (dut3.alu_en) en_cnt++;
        if (t_rv) begin lat = k; got = 1; break; end
      end
      n_checks++; if (en_cnt != 3) begin n_fail++; $display("FAIL sweep_enable_cycles: op %0d got %0d expected 3", i, en_cnt); end
      n_checks++; if (!got || lat != 4) begin n_fail++; $display("FAIL sweep_latency: op %0d got %0d expected 4", i, lat); end
      n_checks++; if (t_ry !== exp_y || t_rid !== id || t_rerr !== 1'b0) begin n_fail++; $display("FAIL sweep_resp: op %0d y=%0h id=%0b err=%0b expected %0h %0b 0", i, t_ry, t_rid, t_rerr, exp_y, id); end
      tick();
    end
  endtask

  // Randomized traffic against a transaction-level model of the arbiter
  task automatic test_random();
    bit pend, pend_start, mlast, exp_rv, exp_en, g0, g1, sid, serr;
    int wt;
    logic [15:0] sy;
    do_reset();
    pend = 0; mlast = 1; wt = 0; sid = 0; serr = 0; sy = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
      a0 = 8'($urandom); b0 = 8'($urandom); c0 = 5'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); c1 = 5'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      pend_start = pend;
      if (pend && wt > 0) wt--;
      exp_rv = pend && (wt == 0);
      exp_en = pend && (wt > 0) && !serr;
      g0 = !pend && v0 && (!v1 || mlast);
      g1 = !pend && v1 && (!v0 || !mlast);
      n_checks++; if (r0 !== g0 || r1 !== g1) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %0b%0b expected %0b%0b", cyc, r0, r1, g0, g1); end
      n_checks++; if (rv !== exp_rv || bsy !== pend) begin n_fail++; $display("FAIL rand_valid_busy: cycle %0d got %0b %0b expected %0b %0b", cyc, rv, bsy, exp_rv, pend); end
      n_checks++; if (dut.alu_en !== exp_en) begin n_fail++; $display("FAIL rand_alu_en: cycle %0d got %0b expected %0b", cyc, dut.alu_en, exp_en); end
      if (exp_rv) begin
        n_checks++; if (ry !== sy || rid !== sid || rerr !== serr) begin n_fail++; $display("FAIL rand_resp: cycle %0d y=%0h id=%0b err=%0b expected %0h %0b %0b", cyc, ry, rid, rerr, sy, sid, serr); end
        if (rr) pend = 0;
      end
      if (!pend_start && (g0 || g1)) begin
        pend  = 1;
        wt    = 2;
        sid   = g1;
        mlast = g1;
        serr  = g1 ? (c1 > 23) : (c0 > 23);
        sy    = g1 ? ref_alu(int'(a1), int'(b1), int'(c1)) : ref_alu(int'(a0), int'(b0), int'(c0));
      end
      tick();
    end
    v0 = 0; v1 = 0; rr = 1;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_bad_cmd();
    test_reset_mid_exec();
    test_settle_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
